// File: rtl/multbooth.sv
// Radix-2 Booth signed multiplier, one iteration per clock.
// Product leaves on outbus as two beats: high half, then low half.
module multbooth #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] M,
    input  logic [N-1:0] Q,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] outbus
);

    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CALC   = 2'd1;
    localparam logic [1:0] OUT_HI = 2'd2;
    localparam logic [1:0] OUT_LO = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [N:0]    a_q, a_d;
    logic [N-1:0]  qr_q, qr_d;
    logic          q1_q, q1_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  m_q, m_d;
    logic [N-1:0]  out_q, out_d;

    logic [N:0] m_ext;
    logic [N:0] sum;

    assign m_ext = {m_q[N-1], m_q};

    always_comb begin
        unique case ({qr_q[0], q1_q})
            2'b10:   sum = a_q - m_ext;
            2'b01:   sum = a_q + m_ext;
            default: sum = a_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        qr_d    = qr_q;
        q1_d    = q1_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        out_d   = out_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = M;
                    a_d     = '0;
                    qr_d    = Q;
                    q1_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                // Add/subtract step folded into the arithmetic shift.
                a_d   = {sum[N], sum[N:1]};
                qr_d  = {sum[0], qr_q[N-1:1]};
                q1_d  = qr_q[0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    out_d   = sum[N:1];
                    state_d = OUT_HI;
                end
            end
            OUT_HI: begin
                out_d   = qr_q;
                state_d = OUT_LO;
            end
            OUT_LO: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            qr_q    <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            m_q     <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            qr_q    <= qr_d;
            q1_q    <= q1_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            out_q   <= out_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == OUT_LO);
    assign outbus = out_q;

endmodule
